// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = a - b (mod 2^WIDTH), one bit per clock,
//   LSB first, with a single borrow flop. Operands are captured on an
//   accepted start; a one-cycle done pulse marks the result as valid. The
//   result outputs hold their value until the next operation completes.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       operation request, honoured only when idle
//   a, b        minuend / subtrahend, captured on the accepting edge
//   busy        high while an operation is shifting or signalling done
//   done        one-cycle completion pulse
//   diff        a - b modulo 2^WIDTH
//   borrow_out  unsigned borrow (a < b)
//   overflow    two's-complement overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    count;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    // Full-subtractor cell on the current LSBs.
    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] r_next;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        x       = a_sh[0];
        y       = b_sh[0];
        d       = x ^ y ^ br;
        br_next = (~x & y) | (~x & br) | (y & br);
        r_next  = {d, r_sh[WIDTH-1:1]};
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // the pre-edge values; the datapath registers here are plain flops, not a
    // memory, so clearing them on reset is cheap and keeps outputs defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            count      <= '0;
            br         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        r_sh  <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        br    <= 1'b0;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    br    <= br_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        // Final bit: publish the result in the same edge.
                        diff       <= r_next;
                        borrow_out <= br_next;
                        overflow   <= (a_msb != b_msb) & (d != a_msb);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): directed vector
// table, hand-written corner sequences, and randomized operands checked
// against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        res_t r;
        int   sd;
        sd   = $signed(ma) - $signed(mb);
        r.d  = W'(int'(ma) - int'(mb));
        r.br = (int'(ma) < int'(mb));
        r.ov = (sd > 127) || (sd < -128);
        return r;
    endfunction

    // One complete operation with latency, busy-length and output-stability checks.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb8, input res_t e, input string tag);
        logic [W-1:0] prev;
        int           n;
        int           busy_cnt;
        logic         stable;
        prev = diff;
        @(negedge clk);
        a = ta; b = tb8; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        n = 1; busy_cnt = 0; stable = 1'b1;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (diff !== prev) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        if (busy) busy_cnt++;
        check({tag, " latency"}, n, W + 1);
        check({tag, " busy_len"}, busy_cnt, W + 1);
        check({tag, " stable"}, stable, 1);
        check({tag, " diff"}, diff, e.d);
        check({tag, " borrow"}, borrow_out, e.br);
        check({tag, " ovf"}, overflow, e.ov);
        @(negedge clk);
        check({tag, " idle_after"}, {done, busy}, 0);
    endtask

    vec_t vecs[4];

    initial begin : main
        res_t e;
        int   n;
        int   done_cnt;
        int   done_at[$];
        logic dz_ok;

        vecs[0] = '{8'd100, 8'd37, 8'h3F, 1'b0, 1'b0};
        vecs[1] = '{8'h05,  8'h0A, 8'hFB, 1'b1, 1'b0};
        vecs[2] = '{8'h80,  8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F,  8'hFF, 8'h80, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        check("reset outs", {busy, done, diff, borrow_out, overflow}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 4; i++) begin
            e.d = vecs[i].ed; e.br = vecs[i].eb; e.ov = vecs[i].eo;
            do_op(vecs[i].va, vecs[i].vb, e, $sformatf("vec%0d", i));
        end

        // Starts during SHIFT and DONE are ignored.
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 1; done_cnt = 0;
        while (n < 22) begin
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("ign diff", diff, 8'h0F);
                    check("ign borrow", borrow_out, 0);
                    check("ign ovf", overflow, 0);
                    check("ign done_time", n, W + 1);
                end
            end
            if (n == 3 || n == 9) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check("ign done_count", done_cnt, 1);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 8'h00; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst mid outs", {busy, done, diff, borrow_out, overflow}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst no_done", done_cnt, 0);
        e = model(8'h00, 8'h01);
        check("model 00-01", e.d, 8'hFF);
        do_op(8'h00, 8'h01, e, "post_rst");

        // start tied high: back-to-back ops every W+2 cycles.
        @(negedge clk);
        a = 8'hAA; b = 8'hAA; start = 1'b1;
        dz_ok = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (done) begin
                done_at.push_back(c);
                if ({diff, borrow_out, overflow} !== 0) dz_ok = 1'b0;
            end
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("b2b count", done_at.size(), 3);
        if (done_at.size() >= 3) begin
            check("b2b gap1", done_at[1] - done_at[0], W + 2);
            check("b2b gap2", done_at[2] - done_at[1], W + 2);
        end
        check("b2b results", dz_ok, 1);

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'h00; end
            if (i == 1) begin ra = 8'hFF; rb = 8'h00; end
            do_op(ra, rb, model(ra, rb), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor that computes DIFF = A - B, one bit per clock, LSB first.
- It uses a single registered borrow flip-flop and is the subtract-direction counterpart of the combinational 1-bit full-adder cell.
- It sits in the arithmetic datapath wherever area matters more than latency.
- It accepts operands on a start pulse and signals completion with a one-cycle done pulse.
- Results are held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  minuend; sampled only on an accepted start.
- b  in  WIDTH  subtrahend; sampled only on an accepted start.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- diff  out  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  out  1  unsigned borrow (1 when a < b unsigned).
- overflow  out  1  two's-complement signed overflow of a - b.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, borrow_out=0, overflow=0; internal shift registers, bit counter and borrow flop cleared.
- Reset mid-operation: the operation is abandoned immediately and the block returns to the reset state. No done pulse is produced for the abandoned operation.
- FSM states are IDLE, SHIFT, DONE.
  - IDLE: if start=1 at the edge, latch a and b into shift regs and keep copies of a[WIDTH-1] and b[WIDTH-1]. Clear borrow, set count=0, go to SHIFT. diff/borrow_out/overflow keep their previous values.
  - SHIFT: each edge consumes bit0 of each shift reg (x=a_sh[0], y=b_sh[0], br=borrow flop).
    - Difference bit: d = x ^ y ^ br.
    - Next borrow: br' = (~x & y) | (~x & br) | (y & br).
    - d shifts into the result reg from the MSB side; operand regs shift right; count increments.
    - On the edge where count == WIDTH-1, the final bit is processed, then diff, borrow_out (=br') and overflow are loaded, and the state goes to DONE.
  - DONE: done=1 for exactly one cycle, then unconditional return to IDLE. A start during DONE is ignored.
- overflow = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb), using the latched operand MSBs.
- Latency: start accepted at edge E. Bits are processed at edges E+1..E+WIDTH. done is high during the cycle following edge E+WIDTH, i.e. WIDTH+1 edges after acceptance. Next start is acceptable at edge E+WIDTH+2; throughput is 1 op per WIDTH+2 cycles.
- Handshake:
  - start while busy=1 is ignored, with no effect on operands or progress.
  - start held high continuously re-triggers on every IDLE cycle.
  - a and b may change freely after the accepting edge.
- Output stability:
  - diff, borrow_out and overflow change only at the edge entering DONE or on reset.
  - They do not toggle during SHIFT.
- Width rules: all arithmetic is modulo 2^WIDTH. The counter is sized to hold WIDTH-1; there is no extra-width internal sum.

Test Plan:
- WIDTH=8, a=100, b=37, start one cycle -> busy high 9 cycles; done pulses at edge 9 after acceptance; diff=8'h3F (63), borrow_out=0, overflow=0.
- a=8'h05, b=8'h0A -> diff=8'hFB, borrow_out=1, overflow=0.
- a=8'h80, b=8'h01 -> diff=8'h7F, borrow_out=0, overflow=1. Then a=8'h7F, b=8'hFF -> diff=8'h80, borrow_out=1, overflow=1.
- Accept a=8'h10, b=8'h01; then pulse start with a=8'hFF, b=8'hFF at cycles 3 and during DONE -> both ignored; result diff=8'h0F, borrow_out=0; only one done pulse.
- Assert rst at cycle 4 of an operation on a=8'h00, b=8'h01 -> all outputs 0 immediately (async), no done pulse. After release, start a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1, overflow=0.
- start tied high with a=b=8'hAA -> back-to-back operations every 10 cycles; each gives diff=8'h00, borrow_out=0, overflow=0; done asserted exactly once per operation.
